// File: rtl/multi_alarm_clock.sv
// -----------------------------------------------------------------------------
// multi_alarm_clock
//   BCD HH:MM timekeeper driven by a prescaled system clock, plus N_ALARMS
//   independently programmable alarm slots. Each slot has a time, an enable and
//   a ring duration in minutes. Snooze and off act on all slots together.
//
// Ports
//   clk        in   1      system clock, CLK_HZ
//   reset      in   1      synchronous, active-low reset
//   load_Clock in   1      pulse: load set_Clock into the time (valid BCD only)
//   set_Clock  in   16     BCD {H1,H0,M1,M0}
//   alarm_wr   in   1      pulse: write slot alarm_sel
//   alarm_sel  in   SEL_W  slot index for alarm_wr
//   set_Alarm  in   16     BCD alarm time for the written slot
//   alarm_en   in   1      enable bit written with the slot
//   dur_Alarm  in   4      ring duration in minutes (0 behaves as 1)
//   off_Alarm  in   1      pulse: silence all slots
//   snooze     in   1      pulse: snooze all ringing slots
//   Clock      out  16     current time, BCD
//   clk_min    out  1      one-cycle pulse on each prescaler rollover
//   Alarm      out  1      high while any slot is ringing
//   alarm_id   out  SEL_W  lowest-index ringing slot, 0 when none
// -----------------------------------------------------------------------------
module multi_alarm_clock #(
  parameter int CLK_HZ     = 1000,
  parameter int N_ALARMS   = 4,
  parameter int SNOOZE_MIN = 5,
  localparam int SEL_W     = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_Clock,
  input  logic [15:0]      set_Clock,
  input  logic             alarm_wr,
  input  logic [SEL_W-1:0] alarm_sel,
  input  logic [15:0]      set_Alarm,
  input  logic             alarm_en,
  input  logic [3:0]       dur_Alarm,
  input  logic             off_Alarm,
  input  logic             snooze,
  output logic [15:0]      Clock,
  output logic             clk_min,
  output logic             Alarm,
  output logic [SEL_W-1:0] alarm_id
);

  localparam int MIN_CYC = CLK_HZ * 60;
  localparam int CNT_W   = (MIN_CYC > 1) ? $clog2(MIN_CYC) : 1;
  localparam logic [CNT_W-1:0] PRESC_TC = CNT_W'(MIN_CYC - 1);
  localparam logic [3:0]       SNZ_LD   = 4'(SNOOZE_MIN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RINGING,
    S_SNOOZED
  } slot_state_e;

  // True when t is a legal 24-hour BCD time.
  function automatic logic bcd_ok(input logic [15:0] t);
    logic ok;
    ok = (t[15:12] <= 4'd2) && (t[11:8] <= 4'd9) &&
         (t[7:4]   <= 4'd5) && (t[3:0]  <= 4'd9);
    if ((t[15:12] == 4'd2) && (t[11:8] > 4'd3)) ok = 1'b0;
    return ok;
  endfunction

  // BCD time one minute later, 23:59 wraps to 00:00.
  function automatic logic [15:0] next_minute(input logic [15:0] t);
    logic [3:0] h1, h0, m1, m0;
    {h1, h0, m1, m0} = t;
    if (m0 != 4'd9) begin
      m0 = m0 + 4'd1;
    end else begin
      m0 = 4'd0;
      if (m1 != 4'd5) begin
        m1 = m1 + 4'd1;
      end else begin
        m1 = 4'd0;
        if ((h1 == 4'd2) && (h0 == 4'd3)) begin
          h1 = 4'd0;
          h0 = 4'd0;
        end else if (h0 != 4'd9) begin
          h0 = h0 + 4'd1;
        end else begin
          h0 = 4'd0;
          h1 = h1 + 4'd1;
        end
      end
    end
    return {h1, h0, m1, m0};
  endfunction

  // A zero duration still rings for one minute.
  function automatic logic [3:0] ring_load(input logic [3:0] dur);
    return (dur == 4'd0) ? 4'd1 : dur;
  endfunction

  // Timekeeper state
  logic [CNT_W-1:0] presc_q, presc_d;
  logic             clk_min_q, clk_min_d;
  logic [15:0]      time_q, time_d;
  logic             time_chg_q, time_chg_d;

  // Slot state
  logic [15:0]   al_time_q  [N_ALARMS];
  logic [15:0]   al_time_d  [N_ALARMS];
  logic [3:0]    al_dur_q   [N_ALARMS];
  logic [3:0]    al_dur_d   [N_ALARMS];
  logic [3:0]    ring_cnt_q [N_ALARMS];
  logic [3:0]    ring_cnt_d [N_ALARMS];
  logic [3:0]    snz_cnt_q  [N_ALARMS];
  logic [3:0]    snz_cnt_d  [N_ALARMS];
  slot_state_e   st_q       [N_ALARMS];
  slot_state_e   st_d       [N_ALARMS];
  logic [N_ALARMS-1:0] al_en_q, al_en_d;

  logic load_ok;
  logic wr_ok;

  assign load_ok = load_Clock && bcd_ok(set_Clock);
  assign wr_ok   = alarm_wr && (32'(alarm_sel) < N_ALARMS) && bcd_ok(set_Alarm);

  // ---- timekeeper: prescaler, minute pulse, time update ----
  always_comb begin
    presc_d   = (presc_q == PRESC_TC) ? '0 : presc_q + CNT_W'(1);
    clk_min_d = (presc_q == PRESC_TC);
    time_d    = time_q;
    if (load_ok) begin
      // A load restarts the minute; a tick landing in the same cycle is lost.
      time_d    = set_Clock;
      presc_d   = '0;
      clk_min_d = 1'b0;
    end else if (clk_min_q) begin
      time_d = next_minute(time_q);
    end
    time_chg_d = (time_d != time_q);
  end

  // ---- alarm slots: match against the freshly updated time ----
  always_comb begin
    al_en_d = al_en_q;
    for (int i = 0; i < N_ALARMS; i++) begin
      al_time_d[i]  = al_time_q[i];
      al_dur_d[i]   = al_dur_q[i];
      ring_cnt_d[i] = ring_cnt_q[i];
      snz_cnt_d[i]  = snz_cnt_q[i];
      st_d[i]       = st_q[i];

      if (wr_ok && (alarm_sel == SEL_W'(i))) begin
        al_time_d[i]  = set_Alarm;
        al_en_d[i]    = alarm_en;
        al_dur_d[i]   = dur_Alarm;
        ring_cnt_d[i] = 4'd0;
        snz_cnt_d[i]  = 4'd0;
        st_d[i]       = S_IDLE;
      end else if (off_Alarm) begin
        st_d[i] = S_IDLE;
      end else if (snooze && (st_q[i] == S_RINGING)) begin
        st_d[i]      = S_SNOOZED;
        snz_cnt_d[i] = SNZ_LD;
      end else if (time_chg_q && al_en_q[i] && (al_time_q[i] == time_q)) begin
        st_d[i]       = S_RINGING;
        ring_cnt_d[i] = ring_load(al_dur_q[i]);
      end else if (clk_min_q) begin
        case (st_q[i])
          S_RINGING: begin
            if (ring_cnt_q[i] <= 4'd1) begin
              st_d[i]       = S_IDLE;
              ring_cnt_d[i] = 4'd0;
            end else begin
              ring_cnt_d[i] = ring_cnt_q[i] - 4'd1;
            end
          end
          S_SNOOZED: begin
            if (snz_cnt_q[i] <= 4'd1) begin
              st_d[i]       = S_RINGING;
              snz_cnt_d[i]  = 4'd0;
              ring_cnt_d[i] = ring_load(al_dur_q[i]);
            end else begin
              snz_cnt_d[i] = snz_cnt_q[i] - 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---- registers ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q    <= '0;
      clk_min_q  <= 1'b0;
      time_q     <= 16'h0000;
      time_chg_q <= 1'b0;
      al_en_q    <= '0;
      for (int i = 0; i < N_ALARMS; i++) begin
        al_time_q[i]  <= 16'h0000;
        al_dur_q[i]   <= 4'd1;
        ring_cnt_q[i] <= 4'd0;
        snz_cnt_q[i]  <= 4'd0;
        st_q[i]       <= S_IDLE;
      end
    end else begin
      presc_q    <= presc_d;
      clk_min_q  <= clk_min_d;
      time_q     <= time_d;
      time_chg_q <= time_chg_d;
      al_en_q    <= al_en_d;
      for (int i = 0; i < N_ALARMS; i++) begin
        al_time_q[i]  <= al_time_d[i];
        al_dur_q[i]   <= al_dur_d[i];
        ring_cnt_q[i] <= ring_cnt_d[i];
        snz_cnt_q[i]  <= snz_cnt_d[i];
        st_q[i]       <= st_d[i];
      end
    end
  end

  // ---- outputs: ring summary with lowest index winning ----
  always_comb begin
    Alarm    = 1'b0;
    alarm_id = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (st_q[i] == S_RINGING) begin
        Alarm    = 1'b1;
        alarm_id = SEL_W'(i);
      end
    end
  end

  assign Clock   = time_q;
  assign clk_min = clk_min_q;

endmodule
